div_iter_unit: RTL

Iterative restoring divider that serves the EX stage's divide request interface. It accepts an operand pair on `div_en_i`, computes a 32-bit signed or unsigned quotient and remainder at one bit per cycle, and reports completion on `finished_o`. The unit is instantiated once per dual-issue EX stage, beside the line-1 EX unit, and is shared by both lines through the line-1 request.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_restore_step.sv | 31 +++
 rtl/div_iter_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
// Holds the FSM state encoding, the default datapath width, the
// iteration-counter width and the divide-by-zero quotient value.
package div_pkg;

  localparam int DIV_WIDTH      = 32;
  localparam int DIV_ITER_CNT_W = $clog2(DIV_WIDTH) + 1;

  // Quotient returned when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_restore_step.sv
// One combinational restoring-division step on magnitudes.
// The partial remainder is the old remainder shifted left by one with the
// next dividend bit appended. The bit shifted out of the remainder MSB
// acts as a carry: when it is set the partial value is at least 2^WIDTH,
// so it always exceeds the divisor, and the modulo-2^WIDTH subtraction
// still produces the correct next remainder.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_quot_bit
);

  logic [WIDTH-1:0] w_partial;
  logic             w_ge;

  // Compare the shifted partial remainder against the divisor and restore
  // (keep the partial value) when the subtraction would go negative.
  always_comb begin
    w_partial  = {i_rem[WIDTH-2:0], i_bit};
    w_ge       = i_rem[WIDTH-1] | (w_partial >= i_divisor);
    o_quot_bit = w_ge;
    o_rem      = w_ge ? (w_partial - i_divisor) : w_partial;
  end

endmodule : div_restore_step

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle.
// Operands are converted to magnitudes on the start edge, divided by the
// unsigned core, and the signs are applied in a final FIX cycle.
// Optional build macro: DIV_EARLY_OUT_EN -- when defined, a zero divisor or
// |dividend| < |divisor| skips the iterations and goes straight to FIX.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_en_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             finished_o,
  output logic             busy_o
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_rem;      // unsigned partial remainder
  logic [WIDTH-1:0] r_dsr;      // divisor magnitude
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_finished;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic             w_dsr_zero;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_bit;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
`ifdef DIV_EARLY_OUT_EN
  logic             w_early;
`endif

  // Operand magnitudes and sign flags, only meaningful on the start edge.
  always_comb begin
    w_dvd_neg  = div_signed_i & dividend_i[WIDTH-1];
    w_dsr_neg  = div_signed_i & divisor_i[WIDTH-1];
    w_dsr_zero = (divisor_i == '0);
    w_dvd_abs  = w_dvd_neg ? (-dividend_i) : dividend_i;
    w_dsr_abs  = w_dsr_neg ? (-divisor_i) : divisor_i;
  end

`ifdef DIV_EARLY_OUT_EN
  // Trivial cases whose result is known without iterating.
  assign w_early = w_dsr_zero | (w_dvd_abs < w_dsr_abs);
`endif

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem      (r_rem),
    .i_divisor  (r_dsr),
    .i_bit      (r_dvd_q[WIDTH-1]),
    .o_rem      (w_step_rem),
    .o_quot_bit (w_step_bit)
  );

  // Sign correction applied in the FIX cycle.
  always_comb begin
    w_quot_fix = r_q_neg ? (-r_dvd_q) : r_dvd_q;
    w_rem_fix  = r_r_neg ? (-r_rem) : r_rem;
  end

  // Control FSM plus operand, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dvd_q    <= '0;
      r_rem      <= '0;
      r_dsr      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_quot     <= '0;
      r_remd     <= '0;
      r_finished <= 1'b0;
    end else if (flush_i) begin
      // Flush aborts everything, including a start seen this same cycle.
      r_state    <= ST_IDLE;
      r_finished <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (div_en_i) begin
            r_dsr   <= w_dsr_abs;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            r_q_neg <= (w_dvd_neg ^ w_dsr_neg) & ~w_dsr_zero;
            r_r_neg <= w_dvd_neg;
            r_cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_dvd_q <= w_dsr_zero ? DIV_ZERO_QUOT[WIDTH-1:0] : '0;
              r_rem   <= w_dvd_abs;
              r_state <= ST_FIX;
            end else begin
              r_dvd_q <= w_dvd_abs;
              r_rem   <= '0;
              r_state <= ST_CALC;
            end
`else
            r_dvd_q <= w_dvd_abs;
            r_rem   <= '0;
            r_state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          r_rem   <= w_step_rem;
          r_dvd_q <= {r_dvd_q[WIDTH-2:0], w_step_bit};
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_quot     <= w_quot_fix;
          r_remd     <= w_rem_fix;
          r_finished <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (!div_en_i) begin
            r_finished <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_finished <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign quotient_o  = r_quot;
  assign remainder_o = r_remd;
  assign finished_o  = r_finished;
  assign busy_o      = (r_state == ST_CALC) || (r_state == ST_FIX);

endmodule : div_iter_unit
